// File: rtl/lap_recorder.sv
// Lap/split capture stage: stores up to DEPTH laps in a circular buffer and
// selects live, frozen or recalled time for the display. Define LAP_OVERWRITE_EN to overwrite the oldest lap when full.
module lap_recorder #(
  parameter int DEPTH     = 8,
  parameter int FREEZE_MS = 3000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1ms,
  input  logic       lap_edge,
  input  logic       recall_edge,
  input  logic       reset_edge,
  input  logic       running,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [6:0] centiseconds,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic [6:0] disp_centiseconds,
  output logic [1:0] mode,
  output logic [4:0] lap_count,
  output logic [4:0] lap_index,
  output logic       full,
  output logic       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int TMR_W = $clog2(FREEZE_MS + 1);
  localparam logic [4:0]       DEPTH_C  = 5'(DEPTH);
  localparam logic [TMR_W-1:0] FREEZE_C = TMR_W'(FREEZE_MS);

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    FREEZE = 2'd1,
    RECALL = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [4:0]         r_count;
  logic [4:0]         r_index;
  logic [TMR_W-1:0]   r_timer;
  logic               r_overflow;
  logic               r_full;
  logic [18:0]        r_disp;
  logic [18:0]        r_mem [DEPTH];

  state_t             w_nState;
  logic [PTR_W-1:0]   w_nWrPtr;
  logic [4:0]         w_nCount;
  logic [4:0]         w_nIndex;
  logic [TMR_W-1:0]   w_nTimer;
  logic               w_nOverflow;
  logic [18:0]        w_nDisp;
  logic               w_memWe;

  logic [18:0]        w_live;
  logic               w_isFull;
  logic               w_lapReq;
  logic               w_lapAccept;
  logic               w_lapLost;
  logic               w_recallOk;
  logic [4:0]         w_stepIdx;
  logic [4:0]         w_incCount;
  logic [PTR_W-1:0]   w_rdAddr;
  logic [TMR_W-1:0]   w_timerInc;

  assign w_live     = {minutes, seconds, centiseconds};
  assign w_isFull   = (r_count == DEPTH_C);
  assign w_lapReq   = lap_edge && running;
  assign w_lapLost  = w_lapReq && w_isFull;
  assign w_recallOk = recall_edge && !running && (r_count != 5'd0);
  assign w_incCount = w_isFull ? r_count : r_count + 5'd1;
  assign w_timerInc = r_timer + TMR_W'(1);

`ifdef LAP_OVERWRITE_EN
  assign w_lapAccept = w_lapReq;
`else
  assign w_lapAccept = w_lapReq && !w_isFull;
`endif

  // Recall enters at the newest lap, then walks toward older ones and wraps.
  assign w_stepIdx = (r_state != RECALL) ? r_count :
                     (r_index <= 5'd1)   ? r_count : r_index - 5'd1;
  assign w_rdAddr  = r_wrPtr - r_count[PTR_W-1:0] + w_stepIdx[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    w_nState    = r_state;
    w_nWrPtr    = r_wrPtr;
    w_nCount    = r_count;
    w_nIndex    = r_index;
    w_nTimer    = r_timer;
    w_nOverflow = r_overflow;
    w_nDisp     = r_disp;
    w_memWe     = 1'b0;

    if (reset_edge) begin
      w_nState    = LIVE;
      w_nWrPtr    = '0;
      w_nCount    = '0;
      w_nIndex    = '0;
      w_nTimer    = '0;
      w_nOverflow = 1'b0;
      w_nDisp     = w_live;
    end else if (w_lapAccept) begin
      w_memWe     = 1'b1;
      w_nState    = FREEZE;
      w_nWrPtr    = r_wrPtr + PTR_W'(1);
      w_nCount    = w_incCount;
      w_nIndex    = w_incCount;
      w_nTimer    = '0;
      w_nOverflow = r_overflow | w_lapLost;
      w_nDisp     = w_live;
    end else begin
      if (w_lapLost) w_nOverflow = 1'b1;
      if (w_recallOk) begin
        w_nState = RECALL;
        w_nIndex = w_stepIdx;
        w_nTimer = '0;
        w_nDisp  = r_mem[w_rdAddr];
      end else begin
        case (r_state)
          LIVE: w_nDisp = w_live;
          FREEZE: begin
            if (clk_1ms) begin
              if (w_timerInc == FREEZE_C) begin
                w_nState = LIVE;
                w_nTimer = '0;
                w_nIndex = '0;
                w_nDisp  = w_live;
              end else begin
                w_nTimer = w_timerInc;
              end
            end
          end
          RECALL: begin
            if (running) begin
              w_nState = LIVE;
              w_nIndex = '0;
              w_nDisp  = w_live;
            end
          end
          default: begin
            w_nState = LIVE;
            w_nIndex = '0;
            w_nDisp  = w_live;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= LIVE;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_index    <= '0;
      r_timer    <= '0;
      r_overflow <= 1'b0;
      r_full     <= 1'b0;
      r_disp     <= '0;
    end else begin
      r_state    <= w_nState;
      r_wrPtr    <= w_nWrPtr;
      r_count    <= w_nCount;
      r_index    <= w_nIndex;
      r_timer    <= w_nTimer;
      r_overflow <= w_nOverflow;
      r_full     <= (w_nCount == DEPTH_C);
      r_disp     <= w_nDisp;
    end
  end

  // Lap storage has no reset; contents are only read back for valid indices.
  always_ff @(posedge clk) begin
    if (!rst && w_memWe) r_mem[r_wrPtr] <= w_live;
  end

  assign disp_minutes      = r_disp[18:13];
  assign disp_seconds      = r_disp[12:7];
  assign disp_centiseconds = r_disp[6:0];
  assign mode              = r_state;
  assign lap_count         = r_count;
  assign lap_index         = r_index;
  assign full              = r_full;
  assign overflow          = r_overflow;

endmodule

// File: tb/tb_lap_recorder.sv
// Directed self-checking bench for lap_recorder (DEPTH=8, FREEZE_MS=3000);
// full-buffer expectations follow LAP_OVERWRITE_EN when it is defined.
module tb_lap_recorder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_1ms = 1'b0;
  logic       lap_edge = 1'b0;
  logic       recall_edge = 1'b0;
  logic       reset_edge = 1'b0;
  logic       running = 1'b0;
  logic [5:0] minutes = '0;
  logic [5:0] seconds = '0;
  logic [6:0] centiseconds = '0;
  logic [5:0] disp_minutes;
  logic [5:0] disp_seconds;
  logic [6:0] disp_centiseconds;
  logic [1:0] mode;
  logic [4:0] lap_count;
  logic [4:0] lap_index;
  logic       full;
  logic       overflow;

  int vectors = 0;
  int miscompares = 0;

  lap_recorder #(.DEPTH(8), .FREEZE_MS(3000)) dut (
    .clk(clk), .rst(rst), .clk_1ms(clk_1ms), .lap_edge(lap_edge),
    .recall_edge(recall_edge), .reset_edge(reset_edge), .running(running),
    .minutes(minutes), .seconds(seconds), .centiseconds(centiseconds),
    .disp_minutes(disp_minutes), .disp_seconds(disp_seconds),
    .disp_centiseconds(disp_centiseconds), .mode(mode), .lap_count(lap_count),
    .lap_index(lap_index), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    lap_edge = 1'b0;
    recall_edge = 1'b0;
    reset_edge = 1'b0;
    clk_1ms = 1'b0;
  endtask

  task automatic setTime(input int m, input int s, input int c);
    minutes = 6'(m);
    seconds = 6'(s);
    centiseconds = 7'(c);
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      clk_1ms = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds, mode, lap_count, lap_index, full, overflow} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got disp=%0d:%0d.%0d mode=%0d cnt=%0d idx=%0d full=%0d ovf=%0d, want all 0",
               disp_minutes, disp_seconds, disp_centiseconds, mode, lap_count, lap_index, full, overflow);
    end
    rst = 1'b0;
    running = 1'b1;
    setTime(0, 5, 0);
    lap_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_freeze: got mode=%0d, want 1", mode);
    end
    rst = 1'b1;
    step();
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds, mode, lap_count, lap_index, full, overflow} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_freeze: got disp=%0d:%0d.%0d mode=%0d cnt=%0d idx=%0d, want all 0",
               disp_minutes, disp_seconds, disp_centiseconds, mode, lap_count, lap_index);
    end
    rst = 1'b0;
    running = 1'b0;
    recall_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd0 || lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL recall_after_reset: got mode=%0d idx=%0d, want 0/0", mode, lap_index);
    end
  endtask

  task automatic test_capture();
    running = 1'b1;
    setTime(0, 12, 34);
    lap_edge = 1'b1;
    step();
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds} !== {6'd0, 6'd12, 7'd34} ||
        mode !== 2'd1 || lap_count !== 5'd1 || lap_index !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL capture: got %0d:%0d.%0d mode=%0d cnt=%0d idx=%0d, want 0:12.34 mode=1 cnt=1 idx=1",
               disp_minutes, disp_seconds, disp_centiseconds, mode, lap_count, lap_index);
    end
    setTime(0, 20, 0);
    strobes(2999);
    vectors++;
    if (mode !== 2'd1 || {disp_minutes, disp_seconds, disp_centiseconds} !== {6'd0, 6'd12, 7'd34}) begin
      miscompares++;
      $display("[TB] FAIL freeze_hold_2999: got mode=%0d disp=%0d:%0d.%0d, want mode=1 0:12.34",
               mode, disp_minutes, disp_seconds, disp_centiseconds);
    end
    strobes(1);
    vectors++;
    if (mode !== 2'd0 || {disp_minutes, disp_seconds, disp_centiseconds} !== {6'd0, 6'd20, 7'd0} ||
        lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL freeze_timeout: got mode=%0d disp=%0d:%0d.%0d idx=%0d, want mode=0 0:20.0 idx=0",
               mode, disp_minutes, disp_seconds, disp_centiseconds, lap_index);
    end
    setTime(0, 30, 0);
    lap_edge = 1'b1;
    step();
    strobes(2999);
    setTime(0, 40, 0);
    lap_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd1 || disp_seconds !== 6'd40 || lap_count !== 5'd3 || lap_index !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL recapture: got mode=%0d sec=%0d cnt=%0d idx=%0d, want 1/40/3/3",
               mode, disp_seconds, lap_count, lap_index);
    end
    strobes(2999);
    vectors++;
    if (mode !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL restart_timer: got mode=%0d, want 1", mode);
    end
    strobes(1);
    vectors++;
    if (mode !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL restart_timeout: got mode=%0d, want 0", mode);
    end
    setTime(0, 50, 0);
    lap_edge = 1'b1;
    clk_1ms = 1'b1;
    step();
    running = 1'b0;
    strobes(2999);
    vectors++;
    if (mode !== 2'd1 || lap_count !== 5'd4) begin
      miscompares++;
      $display("[TB] FAIL coincident_strobe_hold: got mode=%0d cnt=%0d, want 1/4", mode, lap_count);
    end
    strobes(1);
    vectors++;
    if (mode !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL coincident_strobe_timeout: got mode=%0d, want 0", mode);
    end
  endtask

  task automatic test_recall();
    logic [18:0] want;
    int seq [4] = '{3, 2, 1, 3};
    running = 1'b1;
    reset_edge = 1'b1;
    lap_edge = 1'b1;
    step();
    vectors++;
    if (lap_count !== 5'd0 || mode !== 2'd0 || lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_and_lap: got cnt=%0d mode=%0d idx=%0d, want 0/0/0", lap_count, mode, lap_index);
    end
    for (int k = 1; k <= 3; k++) begin
      setTime(0, k, 0);
      lap_edge = 1'b1;
      step();
    end
    running = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      recall_edge = 1'b1;
      step();
      want = {6'd0, 6'(seq[k]), 7'd0};
      vectors++;
      if ({disp_minutes, disp_seconds, disp_centiseconds} !== want || mode !== 2'd2 ||
          lap_index !== 5'(seq[k])) begin
        miscompares++;
        $display("[TB] FAIL recall_step%0d: got %0d:%0d.%0d mode=%0d idx=%0d, want 0:%0d.0 mode=2 idx=%0d",
                 k, disp_minutes, disp_seconds, disp_centiseconds, mode, lap_index, seq[k], seq[k]);
      end
    end
    running = 1'b1;
    setTime(1, 2, 3);
    step();
    vectors++;
    if (mode !== 2'd0 || lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL recall_exit: got mode=%0d idx=%0d, want 0/0", mode, lap_index);
    end
    step();
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds} !== {6'd1, 6'd2, 7'd3}) begin
      miscompares++;
      $display("[TB] FAIL live_passthrough: got %0d:%0d.%0d, want 1:2.3", disp_minutes, disp_seconds, disp_centiseconds);
    end
  endtask

  task automatic test_ignored();
    recall_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd0 || lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL recall_while_running: got mode=%0d idx=%0d, want 0/0", mode, lap_index);
    end
    running = 1'b0;
    lap_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd0 || lap_count !== 5'd3) begin
      miscompares++;
      $display("[TB] FAIL lap_while_stopped: got mode=%0d cnt=%0d, want 0/3", mode, lap_count);
    end
    reset_edge = 1'b1;
    step();
    recall_edge = 1'b1;
    step();
    vectors++;
    if (mode !== 2'd0 || lap_count !== 5'd0 || lap_index !== 5'd0) begin
      miscompares++;
      $display("[TB] FAIL recall_empty: got mode=%0d cnt=%0d idx=%0d, want 0/0/0", mode, lap_count, lap_index);
    end
  endtask

  task automatic test_full();
    logic [18:0] wantNewest;
    logic [18:0] wantOldest;
    running = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      setTime(0, k, 0);
      lap_edge = 1'b1;
      step();
    end
    vectors++;
    if (lap_count !== 5'd8 || full !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill_8: got cnt=%0d full=%0d ovf=%0d, want 8/1/0", lap_count, full, overflow);
    end
    setTime(0, 9, 0);
    lap_edge = 1'b1;
    step();
`ifdef LAP_OVERWRITE_EN
    wantNewest = {6'd0, 6'd9, 7'd0};
    wantOldest = {6'd0, 6'd2, 7'd0};
`else
    wantNewest = {6'd0, 6'd8, 7'd0};
    wantOldest = {6'd0, 6'd1, 7'd0};
`endif
    vectors++;
    if (lap_count !== 5'd8 || overflow !== 1'b1 || mode !== 2'd1 ||
        {disp_minutes, disp_seconds, disp_centiseconds} !== wantNewest) begin
      miscompares++;
      $display("[TB] FAIL lap_when_full: got cnt=%0d ovf=%0d mode=%0d sec=%0d, want 8/1/1 sec=%0d",
               lap_count, overflow, mode, disp_seconds, wantNewest[12:7]);
    end
    running = 1'b0;
    recall_edge = 1'b1;
    step();
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds} !== wantNewest || lap_index !== 5'd8) begin
      miscompares++;
      $display("[TB] FAIL full_recall_newest: got sec=%0d idx=%0d, want sec=%0d idx=8",
               disp_seconds, lap_index, wantNewest[12:7]);
    end
    for (int k = 0; k < 7; k++) begin
      recall_edge = 1'b1;
      step();
    end
    vectors++;
    if ({disp_minutes, disp_seconds, disp_centiseconds} !== wantOldest || lap_index !== 5'd1) begin
      miscompares++;
      $display("[TB] FAIL full_recall_oldest: got sec=%0d idx=%0d, want sec=%0d idx=1",
               disp_seconds, lap_index, wantOldest[12:7]);
    end
    reset_edge = 1'b1;
    step();
    vectors++;
    if (lap_count !== 5'd0 || full !== 1'b0 || overflow !== 1'b0 || mode !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_edge_clears: got cnt=%0d full=%0d ovf=%0d mode=%0d, want 0/0/0/0",
               lap_count, full, overflow, mode);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_recall();
    test_ignored();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
